enemy_ship_unit: RTL and testbench

Per-ship responder for the enemy spawn handshake. The spawn controller pulses `spawn_enable` into this block, and the block then owns one enemy ship:
- places the ship at its spawn column;
- descends it at a divided rate while steering toward the player's column;
- handles destruction on `hit`;
- reports `on_screen` back so the controller never double-spawns a live slot.

Its position outputs feed the sprite renderer and the collision logic directly.

---
 rtl/enemy_ship_unit.sv | 158 +++++++++++++++
 tb/tb_enemy_ship_unit.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/enemy_ship_unit.sv
// enemy_ship_unit: one enemy ship slot covering spawn handshake, divided-rate descent, explosion and escape.
// Define ENEMY_TRACK_EN to steer the ship toward player_x; otherwise enemy_x stays at X_INIT.
module enemy_ship_unit #(
   parameter int X_INIT        = 240,
   parameter int Y_SPAWN       = 0,
   parameter int Y_LIMIT       = 480,
   parameter int X_MAX         = 608,
   parameter int MOVE_DIV      = 500000,
   parameter int X_STEP        = 1,
   parameter int Y_STEP        = 1,
   parameter int EXPLODE_TICKS = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       spawn_enable,
   input  logic       hit,
   input  logic [9:0] player_x,
   output logic [9:0] enemy_x,
   output logic [8:0] enemy_y,
   output logic       on_screen,
   output logic       exploding,
   output logic       spawn_ack,
   output logic       escaped,
   output logic       destroyed
);
   localparam int CNT_W = $clog2(MOVE_DIV);
   localparam int EXP_W = (EXPLODE_TICKS > 1) ? $clog2(EXPLODE_TICKS + 1) : 1;
   localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(MOVE_DIV - 1);

   typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_EXPLODE} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [EXP_W-1:0] exp_cnt_q, exp_cnt_d;
   logic [9:0]       x_q, x_d;
   logic [8:0]       y_q, y_d;
   logic             on_screen_q, on_screen_d;
   logic             exploding_q, exploding_d;
   logic             ack_q, ack_d;
   logic             escaped_q, escaped_d;
   logic             destroyed_q, destroyed_d;

   logic             tick;
   logic [9:0]       y_next;
   logic [9:0]       x_track;

   assign tick   = (cnt_q == TICK_LAST);
   assign y_next = {1'b0, y_q} + 10'(Y_STEP);

`ifdef ENEMY_TRACK_EN
   logic [10:0] diff;
   logic [10:0] x_sum;

   // Snap to player_x when closer than one step so the ship never overshoots.
   always_comb begin
      diff    = 11'd0;
      x_sum   = 11'd0;
      x_track = x_q;
      if (x_q < player_x) begin
         diff    = {1'b0, player_x} - {1'b0, x_q};
         x_sum   = (diff < 11'(X_STEP)) ? {1'b0, player_x} : ({1'b0, x_q} + 11'(X_STEP));
         x_track = (x_sum > 11'(X_MAX)) ? 10'(X_MAX) : x_sum[9:0];
      end else if (x_q > player_x) begin
         diff    = {1'b0, x_q} - {1'b0, player_x};
         x_track = (diff < 11'(X_STEP)) ? player_x : (x_q - 10'(X_STEP));
      end
   end
`else
   logic unused_player;

   assign unused_player = ^player_x;
   assign x_track       = x_q;
`endif

   always_comb begin
      state_d     = state_q;
      cnt_d       = tick ? '0 : cnt_q + 1'b1;
      exp_cnt_d   = exp_cnt_q;
      x_d         = x_q;
      y_d         = y_q;
      ack_d       = 1'b0;
      escaped_d   = 1'b0;
      destroyed_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (spawn_enable) begin
               state_d = S_ACTIVE;
               x_d     = 10'(X_INIT);
               y_d     = 9'(Y_SPAWN);
               cnt_d   = '0;
               ack_d   = 1'b1;
            end
         end
         S_ACTIVE: begin
            // hit outranks a coincident tick, including the escaping one.
            if (hit) begin
               state_d     = S_EXPLODE;
               exp_cnt_d   = EXP_W'(EXPLODE_TICKS);
               destroyed_d = 1'b1;
            end else if (tick) begin
               x_d = x_track;
               if (y_next >= 10'(Y_LIMIT)) begin
                  state_d   = S_IDLE;
                  escaped_d = 1'b1;
               end else begin
                  y_d = y_next[8:0];
               end
            end
         end
         S_EXPLODE: begin
            if (tick) begin
               if (exp_cnt_q <= EXP_W'(1)) begin
                  state_d = S_IDLE;
               end else begin
                  exp_cnt_d = exp_cnt_q - 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      on_screen_d = (state_d != S_IDLE);
      exploding_d = (state_d == S_EXPLODE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         exp_cnt_q   <= '0;
         x_q         <= 10'(X_INIT);
         y_q         <= 9'(Y_SPAWN);
         on_screen_q <= 1'b0;
         exploding_q <= 1'b0;
         ack_q       <= 1'b0;
         escaped_q   <= 1'b0;
         destroyed_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         exp_cnt_q   <= exp_cnt_d;
         x_q         <= x_d;
         y_q         <= y_d;
         on_screen_q <= on_screen_d;
         exploding_q <= exploding_d;
         ack_q       <= ack_d;
         escaped_q   <= escaped_d;
         destroyed_q <= destroyed_d;
      end
   end

   assign enemy_x   = x_q;
   assign enemy_y   = y_q;
   assign on_screen = on_screen_q;
   assign exploding = exploding_q;
   assign spawn_ack = ack_q;
   assign escaped   = escaped_q;
   assign destroyed = destroyed_q;
endmodule

// File: tb/tb_enemy_ship_unit.sv
// Directed testbench for enemy_ship_unit with MOVE_DIV=4, Y_LIMIT=12, Y_STEP=4, X_STEP=2, EXPLODE_TICKS=2.
// Flags are packed as {on_screen, exploding, spawn_ack, escaped, destroyed}.
module tb_enemy_ship_unit;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       spawn_enable = 1'b0;
   logic       hit = 1'b0;
   logic [9:0] player_x = 10'd240;
   logic [9:0] enemy_x;
   logic [8:0] enemy_y;
   logic       on_screen, exploding, spawn_ack, escaped, destroyed;
   logic [4:0] flags;
   logic [18:0] pos;

   int total = 0;
   int bad = 0;

`ifdef ENEMY_TRACK_EN
   localparam logic [9:0] TX1 = 10'd242;
   localparam logic [9:0] TX2 = 10'd244;
   localparam logic [9:0] TX3 = 10'd245;
`else
   localparam logic [9:0] TX1 = 10'd240;
   localparam logic [9:0] TX2 = 10'd240;
   localparam logic [9:0] TX3 = 10'd240;
`endif

   enemy_ship_unit #(
      .X_INIT(240), .Y_SPAWN(0), .Y_LIMIT(12), .X_MAX(608),
      .MOVE_DIV(4), .X_STEP(2), .Y_STEP(4), .EXPLODE_TICKS(2)
   ) dut (
      .clk(clk), .reset(reset), .spawn_enable(spawn_enable), .hit(hit),
      .player_x(player_x), .enemy_x(enemy_x), .enemy_y(enemy_y),
      .on_screen(on_screen), .exploding(exploding), .spawn_ack(spawn_ack),
      .escaped(escaped), .destroyed(destroyed)
   );

   always #5 clk = ~clk;

   assign flags = {on_screen, exploding, spawn_ack, escaped, destroyed};
   assign pos   = {enemy_x, enemy_y};

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) step();
      total++; if (flags !== 5'b00000) begin bad++; $display("FAIL reset_flags got=%b want=%b", flags, 5'b00000); end
      total++; if (pos !== {10'd240, 9'd0}) begin bad++; $display("FAIL reset_pos got=%h want=%h", pos, {10'd240, 9'd0}); end
      reset = 1'b0;
      step();
      total++; if (flags !== 5'b00000) begin bad++; $display("FAIL release_flags got=%b want=%b", flags, 5'b00000); end
      spawn_enable = 1'b1;
      step();
      spawn_enable = 1'b0;
      total++; if (flags !== 5'b10100) begin bad++; $display("FAIL spawn_ack got=%b want=%b", flags, 5'b10100); end
      step();
      total++; if (flags !== 5'b10000) begin bad++; $display("FAIL spawn_ack_once got=%b want=%b", flags, 5'b10000); end
      repeat (12) step();
      total++; if (flags !== 5'b00000) begin bad++; $display("FAIL spawn_drain got=%b want=%b", flags, 5'b00000); end
      $display("test_reset done: total=%0d bad=%0d", total, bad);
   endtask

   task automatic test_descent_escape();
      logic [8:0] ey;
      logic [4:0] ef;
      player_x = 10'd240;
      spawn_enable = 1'b1;
      step();
      spawn_enable = 1'b0;
      for (int k = 1; k <= 13; k++) begin
         step();
         ey = (k < 4) ? 9'd0 : (k < 8) ? 9'd4 : 9'd8;
         ef = (k <= 11) ? 5'b10000 : (k == 12) ? 5'b00010 : 5'b00000;
         total++; if (pos !== {10'd240, ey}) begin bad++; $display("FAIL descent_pos k=%0d got=%h want=%h", k, pos, {10'd240, ey}); end
         total++; if (flags !== ef) begin bad++; $display("FAIL descent_flags k=%0d got=%b want=%b", k, flags, ef); end
      end
      $display("test_descent_escape done: total=%0d bad=%0d", total, bad);
   endtask

   task automatic test_tracking();
      logic [9:0] ex;
      logic [8:0] ey;
      player_x = 10'd245;
      spawn_enable = 1'b1;
      step();
      spawn_enable = 1'b0;
      for (int k = 1; k <= 13; k++) begin
         step();
         ex = (k < 4) ? 10'd240 : (k < 8) ? TX1 : (k < 12) ? TX2 : TX3;
         ey = (k < 4) ? 9'd0 : (k < 8) ? 9'd4 : 9'd8;
         total++; if (pos !== {ex, ey}) begin bad++; $display("FAIL track_pos k=%0d got=%h want=%h", k, pos, {ex, ey}); end
      end
      total++; if (on_screen !== 1'b0) begin bad++; $display("FAIL track_escape got=%b want=0", on_screen); end
      player_x = 10'd240;
      $display("test_tracking done: total=%0d bad=%0d", total, bad);
   endtask

   task automatic test_hit();
      logic [8:0] ey;
      logic [4:0] ef;
      player_x = 10'd240;
      spawn_enable = 1'b1;
      step();
      spawn_enable = 1'b0;
      for (int k = 1; k <= 17; k++) begin
         hit = (k == 8);
         step();
         hit = 1'b0;
         ey = (k < 4) ? 9'd0 : 9'd4;
         ef = (k < 8) ? 5'b10000 : (k == 8) ? 5'b11001 : (k < 16) ? 5'b11000 : 5'b00000;
         total++; if (pos !== {10'd240, ey}) begin bad++; $display("FAIL hit_pos k=%0d got=%h want=%h", k, pos, {10'd240, ey}); end
         total++; if (flags !== ef) begin bad++; $display("FAIL hit_flags k=%0d got=%b want=%b", k, flags, ef); end
      end
      spawn_enable = 1'b1;
      step();
      spawn_enable = 1'b0;
      total++; if (flags !== 5'b10100) begin bad++; $display("FAIL respawn_ack got=%b want=%b", flags, 5'b10100); end
      total++; if (pos !== {10'd240, 9'd0}) begin bad++; $display("FAIL respawn_pos got=%h want=%h", pos, {10'd240, 9'd0}); end
      repeat (12) step();
      total++; if (flags !== 5'b00010) begin bad++; $display("FAIL respawn_escape got=%b want=%b", flags, 5'b00010); end
      step();
      $display("test_hit done: total=%0d bad=%0d", total, bad);
   endtask

   task automatic test_busy_slot();
      logic [8:0] ey;
      logic [4:0] ef;
      spawn_enable = 1'b1;
      step();
      spawn_enable = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         spawn_enable = (k >= 2 && k <= 6);
         hit = (k == 12);
         step();
         spawn_enable = 1'b0;
         hit = 1'b0;
         ey = (k < 4) ? 9'd0 : (k < 8) ? 9'd4 : 9'd8;
         ef = (k < 12) ? 5'b10000 : (k == 12) ? 5'b11001 : (k < 20) ? 5'b11000 : 5'b00000;
         total++; if (pos !== {10'd240, ey}) begin bad++; $display("FAIL busy_pos k=%0d got=%h want=%h", k, pos, {10'd240, ey}); end
         total++; if (flags !== ef) begin bad++; $display("FAIL busy_flags k=%0d got=%b want=%b", k, flags, ef); end
      end
      $display("test_busy_slot done: total=%0d bad=%0d", total, bad);
   endtask

   task automatic test_reset_in_explode();
      spawn_enable = 1'b1;
      step();
      spawn_enable = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         hit = (k == 5);
         step();
         hit = 1'b0;
      end
      total++; if (flags !== 5'b11001) begin bad++; $display("FAIL pre_reset_flags got=%b want=%b", flags, 5'b11001); end
      total++; if (pos !== {10'd240, 9'd4}) begin bad++; $display("FAIL pre_reset_pos got=%h want=%h", pos, {10'd240, 9'd4}); end
      #2;
      reset = 1'b1;
      #1;
      total++; if (flags !== 5'b00000) begin bad++; $display("FAIL async_reset_flags got=%b want=%b", flags, 5'b00000); end
      total++; if (pos !== {10'd240, 9'd0}) begin bad++; $display("FAIL async_reset_pos got=%h want=%h", pos, {10'd240, 9'd0}); end
      step();
      total++; if (flags !== 5'b00000) begin bad++; $display("FAIL held_reset_flags got=%b want=%b", flags, 5'b00000); end
      reset = 1'b0;
      step();
      total++; if (flags !== 5'b00000) begin bad++; $display("FAIL post_reset_flags got=%b want=%b", flags, 5'b00000); end
      $display("test_reset_in_explode done: total=%0d bad=%0d", total, bad);
   endtask

   initial begin
      test_reset();
      test_descent_escape();
      test_tracking();
      test_hit();
      test_busy_slot();
      test_reset_in_explode();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
